max7219_frame_ctrl: RTL
=======================

// Module: max7219_frame_ctrl
// PURPOSE
//  Sequencer for the MAX7219 serial display link (load / dout / clk on uio_out[0]/[1]/[3]).
//  After reset, sends the 5-word device init sequence.
//  On each refresh strobe, snapshots 8 raw segment bytes and sends them as words for digit registers 0x1..0x8.
//  Sits between the clock/BCD/7-seg datapath and the top-level uio pins.
// PARAMETERS
//  SCLK_DIV   2     i_clk cycles per serial-clock half period (>=1); 1 bit time = 2*SCLK_DIV cycles
//  INTENSITY  4'h8  intensity register value sent during init
// PORTS
//  i_clk           in   1   system clock (~10 MHz)
//  i_reset         in   1   synchronous, active-high reset
//  i_stb           in   1   refresh request; single-cycle pulse
//  i_digits        in   64  segment bytes; digit k (addr k+1) = i_digits[8k+7:8k], bit7=DP
//  o_busy          out  1   high while init or a frame is in progress
//  o_frame_done    out  1   1-cycle pulse when the last word of a frame completes
//  o_serial_load   out  1   MAX7219 LOAD; rising edge latches the word
//  o_serial_dout   out  1   MAX7219 DIN, MSB first
//  o_serial_clk    out  1   MAX7219 CLK; device samples on rising edge
// BEHAVIOUR
//  Reset (sync, 1 edge): load=0, dout=0, clk=0, frame_done=0, busy=1; pending cleared; FSM -> INIT word 0.
//  Reset asserted mid-word aborts the word immediately; the init sequence restarts from word 0.
//  FSM: INIT -> IDLE -> FRAME -> IDLE. Each word runs through WORD_SHIFT -> WORD_LOAD -> WORD_GAP.
//  Word format: {4'h0, addr[3:0], data[7:0]}, 16 bits, MSB first.
//  Per bit: dout valid with clk low for SCLK_DIV cycles, then clk high for SCLK_DIV cycles.
//  After bit 0: clk=0, load=1 for 1 bit time (WORD_LOAD), then load=0 for 1 bit time (WORD_GAP).
//  Word time = 18 bit times = 36*SCLK_DIV cycles (72 at default).
//  Init words, in order: 0x0C01 (normal op), 0x0900 (no decode), 0x0A0<INTENSITY>,
//    0x0B07 (scan 8 digits), 0x0F00 (test off).
//  Frame: snapshot all 64 bits of i_digits in the cycle FRAME is entered.
//    Send addr 0x1..0x8 in order from the snapshot. Input changes mid-frame are ignored until the next frame.
//  i_stb in IDLE: FRAME starts on the next cycle.
//  i_stb during INIT or FRAME: sets a 1-bit pending flag. Multiple strobes coalesce into one pending frame.
//  At end of INIT/FRAME: if pending, clear it and enter FRAME directly (busy stays 1, no idle cycle).
//    Otherwise go to IDLE and drop busy.
//  o_frame_done: 1-cycle pulse in the cycle after the last WORD_GAP of a frame; never pulses for INIT.
//  o_busy: falls in that same cycle unless a pending frame follows.
//  Default SCLK_DIV latencies: init = 360 cycles; frame = 576 cycles from FRAME entry to o_frame_done.
//  All outputs are registered; no combinational path from inputs to outputs.
// CONFIGURATION
//  MAX7219_INTENSITY_PORT_EN defined:
//    - adds input i_intensity[3:0]; init uses i_intensity instead of INTENSITY.
//    - i_intensity is registered once per cycle. If it differs from the last value sent, the next frame
//      is prefixed with word 0x0A0<i_intensity>. That frame is 9 words and o_frame_done is delayed by 1 word.
//    - an intensity change alone does not start a frame.
//  Not defined: no port; intensity fixed at INTENSITY; every frame is exactly 8 words.
// STRUCTURE
//  Package max7219_pkg:
//    - register address localparams: NOOP, DIGIT0..7, DECODE, INTENSITY, SCANLIMIT, SHUTDOWN, TEST
//    - init word table (5 x 16b)
//    - FSM state encoding
//  Sub-module max7219_shift_tx:
//    - 16-bit serializer plus bit-time divider
//    - start/word[15:0] in; done pulse out; generates clk/dout/load timing
//  Parent holds: FSM, word index counter, snapshot register, pending flag, word mux.
// TESTING
//  Use the existing MAX7219 mock plus 7seg->BCD decode on the serial pins.
//  1. Release reset, no i_stb
//     -> exactly 5 load pulses: words 0x0C01, 0x0900, 0x0A08, 0x0B07, 0x0F00
//     -> busy falls 360 cycles after reset release; no frame_done.
//  2. IDLE, i_digits = 8 bytes 0x7E,0x30,0x6D,0x79,0x33,0x5B,0x5F,0x70, single i_stb
//     -> mock digits 0..7 = those bytes (BCD 0..7)
//     -> frame_done pulse 576 cycles after FRAME entry.
//  3. Change i_digits 100 cycles into a frame
//     -> mock shows the original snapshot
//     -> a second i_stb during the frame yields exactly one more frame showing the new data.
//  4. Three i_stb during INIT
//     -> one frame follows immediately, busy never drops between them; exactly 1 frame_done.
//  5. Assert i_reset for 1 cycle at cycle 40 of frame word 3
//     -> clk/load/dout=0 next edge; full init re-sent; no frame_done for the aborted frame.
//  6. (MAX7219_INTENSITY_PORT_EN) i_intensity 8 -> 3, then i_stb
//     -> frame is 0x0A03 + 8 digit words; frame_done at 648 cycles.

Source files
------------

// File: rtl/max7219_pkg.sv
// Shared definitions for the MAX7219 frame controller: register map, init table, FSM encodings.
package max7219_pkg;

    localparam logic [3:0] ADDR_NOOP      = 4'h0;
    localparam logic [3:0] ADDR_DIGIT0    = 4'h1;
    localparam logic [3:0] ADDR_DIGIT1    = 4'h2;
    localparam logic [3:0] ADDR_DIGIT2    = 4'h3;
    localparam logic [3:0] ADDR_DIGIT3    = 4'h4;
    localparam logic [3:0] ADDR_DIGIT4    = 4'h5;
    localparam logic [3:0] ADDR_DIGIT5    = 4'h6;
    localparam logic [3:0] ADDR_DIGIT6    = 4'h7;
    localparam logic [3:0] ADDR_DIGIT7    = 4'h8;
    localparam logic [3:0] ADDR_DECODE    = 4'h9;
    localparam logic [3:0] ADDR_INTENSITY = 4'hA;
    localparam logic [3:0] ADDR_SCANLIMIT = 4'hB;
    localparam logic [3:0] ADDR_SHUTDOWN  = 4'hC;
    localparam logic [3:0] ADDR_TEST      = 4'hF;

    localparam int unsigned INIT_WORDS   = 5;
    localparam int unsigned FRAME_DIGITS = 8;

    typedef struct packed {
        logic [3:0] rsvd;
        logic [3:0] addr;
        logic [7:0] data;
    } max7219_word_t;

    // Sequencer states
    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_IDLE  = 2'd1;
    localparam logic [1:0] ST_FRAME = 2'd2;

    // Serializer word phases
    localparam logic [1:0] TX_IDLE  = 2'd0;
    localparam logic [1:0] TX_SHIFT = 2'd1;
    localparam logic [1:0] TX_LOAD  = 2'd2;
    localparam logic [1:0] TX_GAP   = 2'd3;

    function automatic max7219_word_t make_word(input logic [3:0] addr, input logic [7:0] data);
        max7219_word_t w;
        w.rsvd = 4'h0;
        w.addr = addr;
        w.data = data;
        return w;
    endfunction

    // Power-up register programming, sent in index order
    function automatic max7219_word_t init_word(input logic [2:0] idx, input logic [3:0] intensity);
        max7219_word_t w;
        case (idx)
            3'd0:    w = make_word(ADDR_SHUTDOWN, 8'h01);
            3'd1:    w = make_word(ADDR_DECODE, 8'h00);
            3'd2:    w = make_word(ADDR_INTENSITY, {4'h0, intensity});
            3'd3:    w = make_word(ADDR_SCANLIMIT, 8'h07);
            default: w = make_word(ADDR_TEST, 8'h00);
        endcase
        return w;
    endfunction

endpackage

// File: rtl/max7219_shift_tx.sv
// 16-bit MSB-first serializer for the MAX7219 link; one word = 36 half-bit periods.
// The start cycle is the first cycle of the word, so back-to-back words have no gap cycles.
module max7219_shift_tx
    import max7219_pkg::*;
#(
    parameter int unsigned SCLK_DIV = 2
)
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic [15:0] i_word,
    output logic        o_ready_c,
    output logic        o_done_c,
    output logic        o_serial_load,
    output logic        o_serial_dout,
    output logic        o_serial_clk
);

    localparam int unsigned DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);

    logic [1:0]       state, state_nxt, cur_state;
    logic [4:0]       half, half_nxt, cur_half;
    logic [DIV_W-1:0] div_cnt, div_nxt, cur_div;
    logic [15:0]      shreg, shreg_nxt, cur_data;
    logic             load_nxt, dout_nxt, sclk_nxt;
    logic             half_end;

    assign o_ready_c = (state == TX_IDLE);
    assign o_done_c  = (state == TX_GAP) && (half == 5'd1) && (div_cnt == DIV_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= TX_IDLE;
            half          <= '0;
            div_cnt       <= '0;
            shreg         <= '0;
            o_serial_load <= 1'b0;
            o_serial_dout <= 1'b0;
            o_serial_clk  <= 1'b0;
        end else begin
            state         <= state_nxt;
            half          <= half_nxt;
            div_cnt       <= div_nxt;
            shreg         <= shreg_nxt;
            o_serial_load <= load_nxt;
            o_serial_dout <= dout_nxt;
            o_serial_clk  <= sclk_nxt;
        end
    end

    // Current position (a start in idle counts as position 0 of SHIFT), pin values, then advance
    always_comb begin
        cur_state = state;
        cur_half  = half;
        cur_div   = div_cnt;
        cur_data  = shreg;
        if ((state == TX_IDLE) && i_start) begin
            cur_state = TX_SHIFT;
            cur_half  = '0;
            cur_div   = '0;
            cur_data  = i_word;
        end
        state_nxt = cur_state;
        half_nxt  = cur_half;
        div_nxt   = cur_div;
        shreg_nxt = cur_data;
        load_nxt  = 1'b0;
        dout_nxt  = 1'b0;
        sclk_nxt  = 1'b0;
        half_end  = (cur_div == DIV_LAST);

        case (cur_state)
            TX_SHIFT: begin
                sclk_nxt = cur_half[0];
                dout_nxt = cur_data[4'(4'd15 - cur_half[4:1])];
            end
            TX_LOAD: load_nxt = 1'b1;
            default: ;
        endcase

        if (cur_state != TX_IDLE) begin
            if (!half_end) begin
                div_nxt = cur_div + 1'b1;
            end else begin
                div_nxt  = '0;
                half_nxt = cur_half + 5'd1;
                case (cur_state)
                    TX_SHIFT: if (cur_half == 5'd31) begin
                        state_nxt = TX_LOAD;
                        half_nxt  = '0;
                    end
                    TX_LOAD: if (cur_half == 5'd1) begin
                        state_nxt = TX_GAP;
                        half_nxt  = '0;
                    end
                    default: if (cur_half == 5'd1) begin
                        state_nxt = TX_IDLE;
                        half_nxt  = '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/max7219_frame_ctrl.sv
// MAX7219 link sequencer: init sequence after reset, then one 8-digit frame per refresh strobe.
// Optional feature macro: MAX7219_INTENSITY_PORT_EN (runtime intensity input).
module max7219_frame_ctrl
    import max7219_pkg::*;
#(
    parameter int unsigned SCLK_DIV  = 2,
    parameter logic [3:0]  INTENSITY = 4'h8
)
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stb,
    input  logic [63:0] i_digits,
`ifdef MAX7219_INTENSITY_PORT_EN
    input  logic [3:0]  i_intensity,
`endif
    output logic        o_busy,
    output logic        o_frame_done,
    output logic        o_serial_load,
    output logic        o_serial_dout,
    output logic        o_serial_clk
);

    logic [1:0]    state, state_nxt;
    logic [3:0]    idx, idx_nxt, last_idx_c;
    logic [2:0]    digit_sel_c;
    logic          pending, pending_nxt;
    logic          busy_nxt, done_nxt, snap_en_c;
    logic [63:0]   snap;
    logic          tx_start_c, tx_ready_c, tx_done_c;
    max7219_word_t word_c;
    logic          prefix;
    logic [3:0]    init_int_c, frame_int;

`ifdef MAX7219_INTENSITY_PORT_EN
    logic [3:0] int_q, int_sent;

    always_ff @(posedge i_clk) begin
        int_q <= i_intensity;
    end

    // Remember what the device holds; a frame gets an intensity prefix when it differs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            prefix    <= 1'b0;
            int_sent  <= INTENSITY;
            frame_int <= INTENSITY;
        end else begin
            if (snap_en_c) begin
                prefix    <= (int_q != int_sent);
                frame_int <= int_q;
            end
            if (tx_start_c && (state == ST_INIT) && (idx == 4'd2)) begin
                int_sent <= int_q;
            end else if (tx_start_c && (state == ST_FRAME) && prefix && (idx == 4'd0)) begin
                int_sent <= frame_int;
            end
        end
    end

    assign init_int_c = int_q;
`else
    assign prefix     = 1'b0;
    assign frame_int  = INTENSITY;
    assign init_int_c = INTENSITY;
`endif

    assign tx_start_c = (state != ST_IDLE) && tx_ready_c;

    // Word currently due on the link
    always_comb begin
        digit_sel_c = prefix ? 3'(idx - 4'd1) : idx[2:0];
        last_idx_c  = (state == ST_INIT) ? 4'(INIT_WORDS - 1)
                                         : (prefix ? 4'(FRAME_DIGITS) : 4'(FRAME_DIGITS - 1));
        if (state == ST_INIT) begin
            word_c = init_word(idx[2:0], init_int_c);
        end else if (prefix && (idx == 4'd0)) begin
            word_c = make_word(ADDR_INTENSITY, {4'h0, frame_int});
        end else begin
            word_c = make_word(ADDR_DIGIT0 + 4'(digit_sel_c), snap[{digit_sel_c, 3'b000} +: 8]);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state        <= ST_INIT;
            idx          <= '0;
            pending      <= 1'b0;
            o_busy       <= 1'b1;
            o_frame_done <= 1'b0;
        end else begin
            state        <= state_nxt;
            idx          <= idx_nxt;
            pending      <= pending_nxt;
            o_busy       <= busy_nxt;
            o_frame_done <= done_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (snap_en_c) begin
            snap <= i_digits;
        end
    end

    // Sequencer: strobes while busy coalesce into one pending frame
    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        pending_nxt = pending;
        busy_nxt    = o_busy;
        done_nxt    = 1'b0;
        snap_en_c   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (i_stb) begin
                    state_nxt = ST_FRAME;
                    busy_nxt  = 1'b1;
                    snap_en_c = 1'b1;
                end
            end
            default: begin
                if (i_stb) begin
                    pending_nxt = 1'b1;
                end
                if (tx_done_c) begin
                    if (idx != last_idx_c) begin
                        idx_nxt = idx + 4'd1;
                    end else begin
                        idx_nxt  = '0;
                        done_nxt = (state == ST_FRAME);
                        if (pending || i_stb) begin
                            state_nxt   = ST_FRAME;
                            pending_nxt = 1'b0;
                            snap_en_c   = 1'b1;
                        end else begin
                            state_nxt = ST_IDLE;
                            busy_nxt  = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    max7219_shift_tx #(
        .SCLK_DIV (SCLK_DIV)
    ) u_tx (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_start       (tx_start_c),
        .i_word        (word_c),
        .o_ready_c     (tx_ready_c),
        .o_done_c      (tx_done_c),
        .o_serial_load (o_serial_load),
        .o_serial_dout (o_serial_dout),
        .o_serial_clk  (o_serial_clk)
    );

endmodule
